// File: rtl/cordic_job_scheduler.sv
// Round-robin scheduler that shares one CORDIC datapath (pre-unit, iterative core, sign fix-up)
// between NUM_REQ angle requesters, with one job in flight at a time.
module cordic_job_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int ITERATIONS = 16,
  localparam int ID_W      = $clog2(NUM_REQ),
  localparam int ITER_W    = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_angle,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [31:0]             pre_angle,
  input  logic [31:0]             pre_reduced,
  input  logic                    pre_cos_neg,
  input  logic                    pre_sin_neg,
  output logic                    core_load,
  output logic [31:0]             core_angle,
  output logic                    core_en,
  output logic [ITER_W-1:0]       core_iter,
  input  logic [31:0]             core_cos,
  input  logic [31:0]             core_sin,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_cos,
  output logic [31:0]             rsp_sin,
  output logic                    busy
);

  typedef enum logic [2:0] {IDLE, PRE, LOAD, ITER, CAPT, RESP} state_t;

  state_t            state, state_nxt;
  logic [ITER_W-1:0] cnt;
  logic [ID_W-1:0]   last_grant, id_q, grant_idx;
  logic              grant_found, accept, last_iter;
  logic [31:0]       angle_q;
  logic              cos_neg_q, sin_neg_q;

  // Flip the sign bit when requested, but never emit a negative zero.
  function automatic logic [31:0] fix_sign(input logic [31:0] v, input logic neg);
    logic [31:0] r;
    r = {v[31] ^ neg, v[30:0]};
    if (v[30:0] == 31'd0) r[31] = 1'b0;
    return r;
  endfunction

  // Round-robin search starting just after the previous winner; the sum stays below
  // 2*NUM_REQ, so one conditional subtraction implements the wrap.
  always_comb begin
    logic [ID_W:0] cand_w;
    cand_w      = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_w = {1'b0, last_grant} + (ID_W+1)'(k);
      if (cand_w >= (ID_W+1)'(NUM_REQ)) cand_w = cand_w - (ID_W+1)'(NUM_REQ);
      if (!grant_found && req_valid[cand_w[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_w[ID_W-1:0];
      end
    end
  end

  assign accept    = (state == IDLE) && grant_found && !rst;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;
  assign last_iter = (cnt == ITER_W'(ITERATIONS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    core_load = 1'b0;
    core_en   = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = PRE;
      end
      PRE:  state_nxt = LOAD;
      LOAD: begin
        core_load = 1'b1;
        state_nxt = ITER;
      end
      ITER: begin
        core_en = 1'b1;
        if (last_iter) state_nxt = CAPT;
      end
      CAPT: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job context: angle/id on accept, sign flags from the pre-unit in LOAD, result in CAPT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      id_q       <= '0;
      angle_q    <= '0;
      cos_neg_q  <= 1'b0;
      sin_neg_q  <= 1'b0;
      rsp_cos    <= '0;
      rsp_sin    <= '0;
    end else begin
      if (accept) begin
        angle_q    <= req_angle[{grant_idx, 5'd0} +: 32];
        id_q       <= grant_idx;
        last_grant <= grant_idx;
      end
      if (state == LOAD) begin
        cos_neg_q <= pre_cos_neg;
        sin_neg_q <= pre_sin_neg;
      end
      if (state == ITER) cnt <= last_iter ? '0 : cnt + ITER_W'(1);
      if (state == CAPT) begin
        rsp_cos <= fix_sign(core_cos, cos_neg_q);
        rsp_sin <= fix_sign(core_sin, sin_neg_q);
      end
    end
  end

  assign pre_angle  = angle_q;
  assign core_angle = pre_reduced;
  assign core_iter  = core_en ? cnt : '0;
  assign rsp_id     = id_q;

endmodule
